// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, default latencies and counter width for the MIPS multiply/divide unit
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  localparam int MDU_MUL_CYCLES = 5;
  localparam int MDU_DIV_CYCLES = 10;
  localparam int MDU_CNT_W      = 4;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning HI/LO
// Optional MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e           state, state_n;
  logic [MDU_CNT_W-1:0] cnt, cnt_n;
  logic [3:0]           op_r, op_n;
  logic [31:0]          a_r, a_n, b_r, b_n;
  logic [31:0]          hi_n, lo_n;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, mag_q, mag_r, sq, sr, uq, ur;
`ifdef MDU_MADD_EN
  logic [63:0] acc_madd, acc_maddu, acc_msub, acc_msubu;
`endif

  // Behavioural datapath on captured operands; latency comes only from cnt.
  always_comb begin
    prod_s = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
    prod_u = {32'd0, a_r} * {32'd0, b_r};
    mag_a  = a_r[31] ? -a_r : a_r;
    mag_b  = b_r[31] ? -b_r : b_r;
    mag_q  = (b_r == 32'd0) ? 32'd0 : mag_a / mag_b;
    mag_r  = (b_r == 32'd0) ? 32'd0 : mag_a % mag_b;
    sq     = (a_r[31] ^ b_r[31]) ? -mag_q : mag_q;
    sr     = a_r[31] ? -mag_r : mag_r;
    uq     = (b_r == 32'd0) ? 32'd0 : a_r / b_r;
    ur     = (b_r == 32'd0) ? 32'd0 : a_r % b_r;
`ifdef MDU_MADD_EN
    acc_madd  = {hi, lo} + prod_s;
    acc_maddu = {hi, lo} + prod_u;
    acc_msub  = {hi, lo} - prod_s;
    acc_msubu = {hi, lo} - prod_u;
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_r;
    a_n     = a_r;
    b_n     = b_r;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU
`ifdef MDU_MADD_EN
            , MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU
`endif
            : begin
              op_n    = op;
              a_n     = a;
              b_n     = b;
              cnt_n   = MDU_CNT_W'(MUL_CYCLES);
              state_n = MDU_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              op_n    = op;
              a_n     = a;
              b_n     = b;
              cnt_n   = MDU_CNT_W'(DIV_CYCLES);
              state_n = MDU_RUN;
            end
            MDU_MTHI: hi_n = a;
            MDU_MTLO: lo_n = a;
            default: ;
          endcase
        end
      end
      MDU_RUN: begin
        cnt_n = cnt - MDU_CNT_W'(1);
        if (cnt == MDU_CNT_W'(1)) begin
          state_n = MDU_IDLE;
          case (op_r)
            MDU_MULT:  {hi_n, lo_n} = prod_s;
            MDU_MULTU: {hi_n, lo_n} = prod_u;
            MDU_DIV:   if (b_r != 32'd0) begin hi_n = sr; lo_n = sq; end
            MDU_DIVU:  if (b_r != 32'd0) begin hi_n = ur; lo_n = uq; end
`ifdef MDU_MADD_EN
            MDU_MADD:  {hi_n, lo_n} = acc_madd;
            MDU_MADDU: {hi_n, lo_n} = acc_maddu;
            MDU_MSUB:  {hi_n, lo_n} = acc_msub;
            MDU_MSUBU: {hi_n, lo_n} = acc_msubu;
`endif
            default: ;
          endcase
        end
      end
      default: state_n = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      op_r  <= MDU_NOP;
      a_r   <= '0;
      b_r   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_r  <= op_n;
      a_r   <= a_n;
      b_r   <= b_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  assign busy = (state == MDU_RUN);

endmodule
